lzc_normalizer: RTL and testbench
=================================

Name: lzc_normalizer

Overview:
- Two-stage pipelined left-normalizer for unsigned W_IN-bit values.
- Sits directly downstream of count_lead_zero, which it instantiates as its counting core.
- Shifts each input left so its MSB is 1, and reports the shift amount plus a zero flag.
- Feeds integer-to-float conversion and renormalisation paths.
- Uses a valid/ready stream on both sides, with full throughput and backpressure.

Parameters:
- W_IN, 8: data width. Must be a power of 2 and >= 2. Passed unchanged to count_lead_zero.
- W_OUT, $clog2(W_IN): shift-count width. Left at default.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  W_IN  value to normalise.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W_IN  normalised value (MSB = 1 unless out_zero).
- out_shift  output  W_OUT  number of left shifts applied.
- out_zero  output  1  input was all zeros.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). No other clock or reset.
- Reset values: out_valid = 0, out_data = 0, out_shift = 0, out_zero = 0, internal s1_valid = 0.
  - in_ready = 1 in the cycle after reset deasserts. in_ready is combinational, so it also reads 1 while rst is held.
- Reset mid-operation: all in-flight words are discarded, with no partial output.
  - A word presented with in_valid during the rst cycle is not accepted.
- Stage 1 (S1) registers:
  - in_data;
  - count = count_lead_zero(in_data);
  - zero = ~|in_data;
  - s1_valid.
- Stage 2 (S2 = output registers) computes from S1:
  - out_data = s1_data << s1_count, truncated to W_IN bits;
  - out_shift = s1_count;
  - out_zero = s1_zero.
- Zero input: count_lead_zero returns all-ones (W_IN-1) for zero. The block overrides it: out_data = 0, out_shift = 0, out_zero = 1.
- Latency: a word accepted in cycle N appears on out_valid in cycle N+2 when there is no stall.
- Throughput: 1 word/cycle.
- Handshake rules:
  - s2_adv = out_ready | ~out_valid.
  - s1_adv = s2_adv | ~s1_valid.
  - in_ready = s1_adv.
  - A transfer occurs on valid & ready at a port.
- Register load rules:
  - S2 loads when s2_adv. out_valid <= s1_valid.
  - S1 loads when s1_adv. s1_valid <= in_valid.
  - Both stages hold their contents when not advancing.
- While out_valid = 1 and out_ready = 0: out_data, out_shift and out_zero stay stable.
- The combinational path out_ready -> in_ready is permitted and documented for integrators.
- Ordering: strictly in order. No drop and no duplication under any ready pattern.
- Full pipeline (both stages valid, out_ready = 0): in_ready = 0.
- Simultaneous input accept and output pop when full: accepted the same cycle, with no bubble.
- in_valid may drop without a transfer. in_data is only sampled on a transfer.
- Widths:
  - shift is a logical left shift with zero fill;
  - out_shift ranges 0..W_IN-1;
  - no arithmetic carries exist.
- Elaboration: an assertion flags W_IN not a power of 2 or W_IN < 2.

Test Plan:
- Sweep at W_IN=8, out_ready=1, back-to-back inputs 0x01, 0x80, 0x13, 0x40.
  - Outputs on cycles N+2..N+5 in order: (0x80,7,0), (0x80,0,0), (0x98,3,0), (0x80,1,0).
- in_data=0x00 -> out_data=0x00, out_shift=0, out_zero=1. The next input 0x02 gives (0x80,6,0).
- Backpressure: stream 0x01,0x02,0x04,0x08 with out_ready held low for 4 cycles.
  - in_ready drops after 2 words are accepted.
  - out_data holds 0x80 / shift 7, stable.
  - After release, all 4 outputs appear in order: shifts 7,6,5,4.
- Reset mid-stream: rst pulsed for 1 cycle with both stages valid.
  - Next cycle out_valid=0 and outputs=0.
  - A fresh 0x10 gives (0x80,3,0) 2 cycles after acceptance.
- Random: 10k random in_data with random in_valid/out_ready, at W_IN=2, 8 and 32.
  - Scoreboard matches a reference model in order.
  - out_data[W_IN-1]==1 whenever !out_zero.
  - Outputs are stable while stalled.
- W_IN=2: in 0b01 -> (0b10,1,0); 0b10 -> (0b10,0,0); 0b00 -> (0b00,0,1).

Source files
------------

// File: rtl/lzc_normalizer.sv
// Two-stage pipelined left-normalizer for unsigned W_IN-bit values.
// Shifts each accepted word left until its MSB is 1 and reports the shift
// amount plus a zero flag. Valid/ready stream on both sides, full
// throughput, backpressure-safe.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream word present
//   in_ready   word accepted this cycle (combinational, depends on out_ready)
//   in_data    value to normalise
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_data   normalised value (MSB = 1 unless out_zero)
//   out_shift  number of left shifts applied
//   out_zero   input was all zeros

// Leading-zero counter; returns W_IN-1 (all ones) for an all-zero input.
module count_lead_zero #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = $clog2(W_IN)
) (
  input  logic [W_IN-1:0]  data,
  output logic [W_OUT-1:0] count_c
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_c = W_OUT'(W_IN - 1);
    for (int unsigned i = 0; i < W_IN; i++) begin
      if (data[i]) count_c = W_OUT'(W_IN - 1 - i);
    end
  end

endmodule

module lzc_normalizer #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = $clog2(W_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_IN-1:0]  out_data,
  output logic [W_OUT-1:0] out_shift,
  output logic             out_zero
);

  // Elaboration-time parameter sanity check.
  if ((W_IN < 2) || ((W_IN & (W_IN - 1)) != 0)) begin : g_bad_width
    $error("lzc_normalizer: W_IN must be a power of 2 and >= 2");
  end

  logic             s1_valid;
  logic [W_IN-1:0]  s1_data;
  logic [W_OUT-1:0] s1_count;
  logic             s1_zero;

  logic [W_OUT-1:0] lz_count_c;
  logic             s2_adv_c;
  logic             s1_adv_c;

  count_lead_zero #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT)
  ) u_clz (
    .data    (in_data),
    .count_c (lz_count_c)
  );

  // Stage advance: a stage may load when it is empty or its consumer drains.
  // out_ready reaches in_ready combinationally so a full pipe can accept and
  // pop in the same cycle without a bubble.
  assign s2_adv_c = out_ready | ~out_valid;
  assign s1_adv_c = s2_adv_c | ~s1_valid;
  assign in_ready = s1_adv_c;

  // Stage 1: capture input word, its leading-zero count and zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_count <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_count <= lz_count_c;
        s1_zero  <= ~|in_data;
      end
    end
  end

  // Stage 2: shift and register outputs; zero input reports shift 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= s1_zero ? '0 : W_IN'(s1_data << s1_count);
        out_shift <= s1_zero ? '0 : s1_count;
        out_zero  <= s1_zero;
      end
    end
  end

endmodule

// File: tb/tb_lzc_normalizer.sv
// Directed bench for lzc_normalizer at W_IN=8 and W_IN=2, plus a short
// random-handshake stream at W_IN=8 checked against an in-order model.
module tb_lzc_normalizer;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [7:0] in_data, out_data;
  logic [2:0] out_shift;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_zero2;
  logic [1:0] in_data2, out_data2;
  logic [0:0] out_shift2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  lzc_normalizer #(.W_IN(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shift(out_shift), .out_zero(out_zero)
  );

  lzc_normalizer #(.W_IN(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_shift(out_shift2), .out_zero(out_zero2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string tag, input logic v, input logic [7:0] d,
                         input logic [2:0] s, input logic z);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".shift"}, 32'(out_shift), 32'(s));
    check({tag, ".zero"},  32'(out_zero),  32'(z));
  endtask

  task automatic expect2(input string tag, input logic v, input logic [1:0] d,
                         input logic s, input logic z);
    check({tag, ".valid"}, 32'(out_valid2), 32'(v));
    check({tag, ".data"},  32'(out_data2),  32'(d));
    check({tag, ".shift"}, 32'(out_shift2), 32'(s));
    check({tag, ".zero"},  32'(out_zero2),  32'(z));
  endtask

  // Reference: scan from MSB for the first one.
  function automatic logic [11:0] ref_norm(input logic [7:0] x);
    logic [2:0] s;
    logic       z;
    s = 3'd0;
    z = 1'b1;
    for (int p = 7; p >= 0; p--) begin
      if (z && x[p]) begin
        z = 1'b0;
        s = 3'(7 - p);
      end
    end
    return {z, s, (x << s)};
  endfunction

  initial begin
    logic [7:0]  sw_in  [4];
    logic [7:0]  bp_in  [4];
    logic [2:0]  bp_sh  [4];
    logic [7:0]  sw_d   [4];
    logic [2:0]  sw_s   [4];
    logic [1:0]  w2_in  [3];
    logic [1:0]  w2_d   [3];
    logic        w2_s   [3];
    logic        w2_z   [3];
    logic [7:0]  sb_q   [$];
    logic [11:0] r;
    logic [7:0]  held_d;
    logic [2:0]  held_s;
    logic        held_z;
    logic        prev_stall;
    int          idx, oidx, sent, got;

    sw_in = '{8'h01, 8'h80, 8'h13, 8'h40};
    sw_d  = '{8'h80, 8'h80, 8'h98, 8'h80};
    sw_s  = '{3'd7, 3'd0, 3'd3, 3'd1};
    bp_in = '{8'h01, 8'h02, 8'h04, 8'h08};
    bp_sh = '{3'd7, 3'd6, 3'd5, 3'd4};
    w2_in = '{2'b01, 2'b10, 2'b00};
    w2_d  = '{2'b10, 2'b10, 2'b00};
    w2_s  = '{1'b1, 1'b0, 1'b0};
    w2_z  = '{1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    tick(); tick();
    expect8("reset", 1'b0, 8'h00, 3'd0, 1'b0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    expect2("reset2", 1'b0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Back-to-back sweep, latency 2.
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? sw_in[c] : 8'h00;
      #1;
      if (c >= 2) expect8($sformatf("sweep%0d", c - 2), 1'b1, sw_d[c-2], sw_s[c-2], 1'b0);
      else        check($sformatf("sweep_lat%0d", c), 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    check("sweep_drain", 32'(out_valid), 32'd0);

    // Zero input then a normal word.
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 2);
      in_data  = (c == 0) ? 8'h00 : 8'h02;
      #1;
      if (c == 2) expect8("zero", 1'b1, 8'h00, 3'd0, 1'b1);
      if (c == 3) expect8("after_zero", 1'b1, 8'h80, 3'd6, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: out_ready low for 4 cycles.
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 4);
      in_data  = bp_in[idx];
      #1;
      if (c >= 2) begin
        check($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
        expect8($sformatf("bp_hold%0d", c), 1'b1, 8'h80, 3'd7, 1'b0);
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    check("bp_accepted", 32'(idx), 32'd2);
    oidx = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && oidx < 4; c++) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? bp_in[idx] : 8'h00;
      #1;
      if (out_valid) begin
        expect8($sformatf("bp_out%0d", oidx), 1'b1, 8'h80, bp_sh[oidx], 1'b0);
        oidx++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_count", 32'(oidx), 32'd4);
    tick();

    // Reset mid-stream with both stages full.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = bp_in[c];
      tick();
    end
    rst = 1'b1;
    in_data = 8'h04;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    expect8("rst_mid", 1'b0, 8'h00, 3'd0, 1'b0);
    tick();
    check("rst_no_accept", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    in_valid = 1'b0;
    tick();
    expect8("post_rst", 1'b1, 8'h80, 3'd3, 1'b0);
    tick();

    // W_IN=2 directed.
    for (int c = 0; c < 5; c++) begin
      in_valid2 = (c < 3);
      in_data2  = (c < 3) ? w2_in[c] : 2'b00;
      #1;
      if (c >= 2) expect2($sformatf("w2_%0d", c - 2), 1'b1, w2_d[c-2], w2_s[c-2], w2_z[c-2]);
      tick();
    end
    in_valid2 = 1'b0;

    // Random handshakes against the reference model.
    sent = 0; got = 0; prev_stall = 1'b0;
    held_d = '0; held_s = '0; held_z = 1'b0;
    for (int c = 0; c < 3000 && got < 300; c++) begin
      in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom >> ($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid) begin
        if (prev_stall) begin
          check("stall_data",  32'(out_data),  32'(held_d));
          check("stall_shift", 32'(out_shift), 32'(held_s));
          check("stall_zero",  32'(out_zero),  32'(held_z));
        end
        if (!out_zero) check("msb_set", 32'(out_data[7]), 32'd1);
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_extra", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            r = ref_norm(sb_q.pop_front());
            check($sformatf("rnd%0d", got), {20'd0, out_zero, out_shift, out_data}, 32'(r));
          end
          got++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data; held_s = out_shift; held_z = out_zero;
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("rnd_count", 32'(got), 32'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
